// File: rtl/dyn_branch_predictor_if.sv
// Pipeline-side bundle for the dynamic branch predictor: F/D/E instruction slots,
// E-stage resolution inputs, and the PC-mux/prediction/perf outputs.
interface dyn_branch_predictor_if #(
    parameter int PERF_W = 32
);
    logic              stall_in;
    logic [31:0]       pc_F;
    logic [31:0]       instF;
    logic              killF;
    logic [31:0]       pc_E;
    logic [31:0]       instE;
    logic              killE;
    logic [31:0]       instD;
    logic              killD;
    logic              taken_E;
    logic [31:0]       target_E;
    logic              pred_taken_E;
    logic [31:0]       pred_target_E;
    logic [2:0]        pcmux_sel_out;
    logic              pred_taken_F;
    logic [31:0]       pred_target_F;
    logic              predict_fail;
    logic              stall_out;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output stall_in, pc_F, instF, killF, pc_E, instE, killE, instD, killD,
        output taken_E, target_E, pred_taken_E, pred_target_E,
        input  pcmux_sel_out, pred_taken_F, pred_target_F, predict_fail,
        input  stall_out, perf_branches, perf_mispredicts
    );

    modport slave (
        input  stall_in, pc_F, instF, killF, pc_E, instE, killE, instD, killD,
        input  taken_E, target_E, pred_taken_E, pred_target_E,
        output pcmux_sel_out, pred_taken_F, pred_target_F, predict_fail,
        output stall_out, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/dyn_branch_predictor.sv
// Dynamic branch predictor: 2-bit counters plus tagged BTB predict B-type branches at F,
// E resolves/corrects mispredicts and trains the tables; saturating perf counters.
module dyn_branch_predictor #(
    parameter int         IDX_W          = 6,
    parameter int         TAG_W          = 8,
    parameter logic [1:0] CNT_INIT       = 2'b01,
    parameter bit         ENABLE_DYNAMIC = 1'b1,
    parameter int         PERF_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dyn_branch_predictor_if.slave bus
);

    localparam int         ENTRIES     = 1 << IDX_W;
    localparam logic [4:0] OP_B        = 5'b11000;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [2:0] SEL_PC4     = 3'd0;
    localparam logic [2:0] SEL_JAL     = 3'd3;
    localparam logic [2:0] SEL_JALR    = 3'd4;
    localparam logic [2:0] SEL_TGT_E   = 3'd5;
    localparam logic [2:0] SEL_PRED    = 3'd6;
    localparam logic [2:0] SEL_RECOVER = 3'd7;

    logic [1:0]        cnt_q [ENTRIES];
    logic [1:0]        cnt_d [ENTRIES];
    logic [TAG_W-1:0]  tag_q [ENTRIES];
    logic [TAG_W-1:0]  tag_d [ENTRIES];
    logic [31:0]       tgt_q [ENTRIES];
    logic [31:0]       tgt_d [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    logic [IDX_W-1:0]  idx_f, idx_e;
    logic [TAG_W-1:0]  tag_f, tag_e;
    logic              f_is_b, f_is_jal, d_is_jalr, e_is_b;
    logic              hit_f, pred_taken_f, e_valid, e_fail, update;
    logic [31:0]       pc_f_plus4;
    logic              unused_bits;

    assign idx_f = bus.pc_F[IDX_W+1:2];
    assign tag_f = bus.pc_F[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_e = bus.pc_E[IDX_W+1:2];
    assign tag_e = bus.pc_E[IDX_W+TAG_W+1:IDX_W+2];

    assign f_is_b    = (bus.instF[6:2] == OP_B);
    assign f_is_jal  = (bus.instF[6:2] == OP_JAL);
    assign d_is_jalr = (bus.instD[6:2] == OP_JALR);
    assign e_is_b    = (bus.instE[6:2] == OP_B);

    assign unused_bits = ^{bus.instF[31:7], bus.instF[1:0], bus.instD[31:7], bus.instD[1:0],
                           bus.instE[31:7], bus.instE[1:0],
                           bus.pc_E[31:IDX_W+TAG_W+2], bus.pc_E[1:0]};

    // F-side lookup reads the registered tables only, so an E write lands a cycle later
    assign hit_f        = ENABLE_DYNAMIC && valid_q[idx_f] && (tag_q[idx_f] == tag_f)
                          && cnt_q[idx_f][1];
    assign pred_taken_f = hit_f && f_is_b && !bus.killF;
    assign pc_f_plus4   = bus.pc_F + 32'd4;

    assign e_valid = !bus.killE && e_is_b;
    assign e_fail  = (bus.taken_E != bus.pred_taken_E)
                   || (bus.taken_E && bus.pred_taken_E && (bus.target_E != bus.pred_target_E));
    assign update  = !bus.stall_in && e_valid;

    always_comb begin
        bus.pred_taken_F     = pred_taken_f;
        bus.pred_target_F    = pred_taken_f ? tgt_q[idx_f] : pc_f_plus4;
        bus.stall_out        = bus.stall_in;
        bus.perf_branches    = perf_br_q;
        bus.perf_mispredicts = perf_mis_q;
        bus.predict_fail     = 1'b0;
        bus.pcmux_sel_out    = SEL_PC4;
        if (bus.stall_in) begin
            bus.pcmux_sel_out = SEL_PC4;
        end else if (e_valid && e_fail) begin
            bus.predict_fail  = 1'b1;
            bus.pcmux_sel_out = bus.taken_E ? SEL_TGT_E : SEL_RECOVER;
        end else if (!bus.killD && d_is_jalr) begin
            bus.pcmux_sel_out = SEL_JALR;
        end else if (!bus.killF) begin
            if (f_is_b && pred_taken_f) begin
                bus.pcmux_sel_out = SEL_PRED;
            end else if (f_is_jal) begin
                bus.pcmux_sel_out = SEL_JAL;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        tgt_d      = tgt_q;
        valid_d    = valid_q;
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (update) begin
            if (perf_br_q != '1) begin
                perf_br_d = perf_br_q + PERF_W'(1);
            end
            if (e_fail && (perf_mis_q != '1)) begin
                perf_mis_d = perf_mis_q + PERF_W'(1);
            end
            if (ENABLE_DYNAMIC) begin
                if (bus.taken_E) begin
                    if (cnt_q[idx_e] != 2'b11) begin
                        cnt_d[idx_e] = cnt_q[idx_e] + 2'b01;
                    end
                    valid_d[idx_e] = 1'b1;
                    tag_d[idx_e]   = tag_e;
                    tgt_d[idx_e]   = bus.target_E;
                end else if (cnt_q[idx_e] != 2'b00) begin
                    cnt_d[idx_e] = cnt_q[idx_e] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            valid_q    <= '0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            tgt_q      <= tgt_d;
            valid_q    <= valid_d;
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Directed bench: one default predictor, one static-mode build and one PERF_W=4 build
// all see the same pipeline stimulus; expected values are hand-computed per step.
module tb_dyn_branch_predictor;

    localparam logic [31:0] INST_B    = 32'h0000_0063;
    localparam logic [31:0] INST_JAL  = 32'h0000_006F;
    localparam logic [31:0] INST_JALR = 32'h0000_0067;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_in, killF, killE, killD, taken_E, pred_taken_E;
    logic [31:0] pc_F, instF, pc_E, instE, instD, target_E, pred_target_E;
    int          tests_run;
    int          tests_failed;

    dyn_branch_predictor_if                bus0 ();
    dyn_branch_predictor_if                bus1 ();
    dyn_branch_predictor_if #(.PERF_W(4))  bus2 ();

    dyn_branch_predictor                            u_dyn    (.clk(clk), .rst_n(rst_n), .bus(bus0));
    dyn_branch_predictor #(.ENABLE_DYNAMIC(1'b0))   u_static (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dyn_branch_predictor #(.PERF_W(4))              u_narrow (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.stall_in = stall_in;  assign bus1.stall_in = stall_in;  assign bus2.stall_in = stall_in;
    assign bus0.pc_F = pc_F;          assign bus1.pc_F = pc_F;          assign bus2.pc_F = pc_F;
    assign bus0.instF = instF;        assign bus1.instF = instF;        assign bus2.instF = instF;
    assign bus0.killF = killF;        assign bus1.killF = killF;        assign bus2.killF = killF;
    assign bus0.pc_E = pc_E;          assign bus1.pc_E = pc_E;          assign bus2.pc_E = pc_E;
    assign bus0.instE = instE;        assign bus1.instE = instE;        assign bus2.instE = instE;
    assign bus0.killE = killE;        assign bus1.killE = killE;        assign bus2.killE = killE;
    assign bus0.instD = instD;        assign bus1.instD = instD;        assign bus2.instD = instD;
    assign bus0.killD = killD;        assign bus1.killD = killD;        assign bus2.killD = killD;
    assign bus0.taken_E = taken_E;    assign bus1.taken_E = taken_E;    assign bus2.taken_E = taken_E;
    assign bus0.target_E = target_E;  assign bus1.target_E = target_E;  assign bus2.target_E = target_E;
    assign bus0.pred_taken_E = pred_taken_E;
    assign bus1.pred_taken_E = pred_taken_E;
    assign bus2.pred_taken_E = pred_taken_E;
    assign bus0.pred_target_E = pred_target_E;
    assign bus1.pred_target_E = pred_target_E;
    assign bus2.pred_target_E = pred_target_E;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Quiet pipeline: B-type at 0x100 in F, D and E slots killed
    task automatic set_idle();
        stall_in      = 1'b0;
        pc_F          = 32'h100;
        instF         = INST_B;
        killF         = 1'b0;
        pc_E          = 32'h100;
        instE         = INST_B;
        killE         = 1'b1;
        instD         = INST_NOP;
        killD         = 1'b1;
        taken_E       = 1'b0;
        target_E      = 32'h0;
        pred_taken_E  = 1'b0;
        pred_target_E = 32'h0;
    endtask

    task automatic apply_stimulus(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                                  input logic ptaken, input logic [31:0] ptgt);
        killE         = 1'b0;
        instE         = INST_B;
        pc_E          = pc;
        taken_E       = taken;
        target_E      = tgt;
        pred_taken_E  = ptaken;
        pred_target_E = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_output("reset_perf_br", bus0.perf_branches, 32'd0);
        check_output("reset_perf_mis", bus0.perf_mispredicts, 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("empty_sel", {29'd0, bus0.pcmux_sel_out}, 32'd0);
        check_output("empty_taken", {31'd0, bus0.pred_taken_F}, 32'd0);
        check_output("empty_target", bus0.pred_target_F, 32'h104);
        check_output("empty_fail", {31'd0, bus0.predict_fail}, 32'd0);
        tick();

        // First taken resolution: not predicted, redirect to target_E
        apply_stimulus(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        check_output("e1_fail", {31'd0, bus0.predict_fail}, 32'd1);
        check_output("e1_sel", {29'd0, bus0.pcmux_sel_out}, 32'd5);
        tick();

        // Counter now 10 and BTB filled, so F already predicts while E still redirects
        apply_stimulus(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        check_output("e2_fail", {31'd0, bus0.predict_fail}, 32'd1);
        check_output("e2_sel", {29'd0, bus0.pcmux_sel_out}, 32'd5);
        check_output("e2_f_taken", {31'd0, bus0.pred_taken_F}, 32'd1);
        check_output("e2_static_f_taken", {31'd0, bus1.pred_taken_F}, 32'd0);
        tick();

        set_idle();
        #1;
        check_output("pred_sel", {29'd0, bus0.pcmux_sel_out}, 32'd6);
        check_output("pred_target", bus0.pred_target_F, 32'h200);
        check_output("static_sel", {29'd0, bus1.pcmux_sel_out}, 32'd0);
        check_output("static_target", bus1.pred_target_F, 32'h104);
        check_output("perf_br_2", bus0.perf_branches, 32'd2);
        tick();

        // Predicted taken, actually not taken: recover to pc_E+4
        apply_stimulus(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        check_output("nt_fail", {31'd0, bus0.predict_fail}, 32'd1);
        check_output("nt_sel", {29'd0, bus0.pcmux_sel_out}, 32'd7);
        tick();
        set_idle();
        #1;
        check_output("nt_perf_mis", bus0.perf_mispredicts, 32'd3);
        check_output("cnt10_still_pred", {29'd0, bus0.pcmux_sel_out}, 32'd6);
        tick();

        // Stall masks a mispredict and freezes all state
        apply_stimulus(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        stall_in = 1'b1;
        #1;
        check_output("stall_out", {31'd0, bus0.stall_out}, 32'd1);
        check_output("stall_sel", {29'd0, bus0.pcmux_sel_out}, 32'd0);
        check_output("stall_fail", {31'd0, bus0.predict_fail}, 32'd0);
        tick();
        set_idle();
        #1;
        check_output("stall_perf_br", bus0.perf_branches, 32'd3);
        check_output("stall_perf_mis", bus0.perf_mispredicts, 32'd3);
        check_output("stall_cnt_kept", {29'd0, bus0.pcmux_sel_out}, 32'd6);
        tick();

        // Correct prediction in E, JALR in D beats the predicted F branch
        apply_stimulus(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        killD = 1'b0;
        instD = INST_JALR;
        #1;
        check_output("jalr_sel", {29'd0, bus0.pcmux_sel_out}, 32'd4);
        check_output("jalr_fail", {31'd0, bus0.predict_fail}, 32'd0);
        tick();

        // Right direction, wrong target: F still sees the old target this cycle
        set_idle();
        apply_stimulus(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        #1;
        check_output("tgt_fail_sel", {29'd0, bus0.pcmux_sel_out}, 32'd5);
        check_output("no_bypass_target", bus0.pred_target_F, 32'h200);
        tick();
        set_idle();
        #1;
        check_output("new_target", bus0.pred_target_F, 32'h300);
        check_output("perf_mis_4", bus0.perf_mispredicts, 32'd4);

        instF = INST_JAL;
        #1;
        check_output("jal_sel", {29'd0, bus0.pcmux_sel_out}, 32'd3);
        check_output("jal_taken", {31'd0, bus0.pred_taken_F}, 32'd0);
        instF = INST_B;
        killF = 1'b1;
        #1;
        check_output("killf_sel", {29'd0, bus0.pcmux_sel_out}, 32'd0);
        check_output("killf_taken", {31'd0, bus0.pred_taken_F}, 32'd0);
        killF = 1'b0;
        pc_F  = 32'h200;
        #1;
        check_output("alias_sel", {29'd0, bus0.pcmux_sel_out}, 32'd0);
        check_output("alias_target", bus0.pred_target_F, 32'h204);
        tick();

        // Twelve mispredicts: the 4-bit build pins both counters at 4'hF
        set_idle();
        killF = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(32'h400, 1'b0, 32'h0, 1'b1, 32'h500);
            tick();
        end
        check_output("narrow_mis_sat", {28'd0, bus2.perf_mispredicts}, 32'hF);
        check_output("narrow_br_sat", {28'd0, bus2.perf_branches}, 32'hF);
        check_output("wide_mis_16", bus0.perf_mispredicts, 32'd16);
        tick();
        check_output("narrow_mis_hold", {28'd0, bus2.perf_mispredicts}, 32'hF);
        check_output("wide_mis_17", bus0.perf_mispredicts, 32'd17);
        check_output("static_br_18", bus1.perf_branches, 32'd18);

        // Retrain idx 0 from 00 up to 10, then reset mid-cycle
        set_idle();
        apply_stimulus(32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
        tick();
        tick();
        set_idle();
        #1;
        check_output("retrain_sel", {29'd0, bus0.pcmux_sel_out}, 32'd6);
        check_output("static_never_6", {29'd0, bus1.pcmux_sel_out}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_sel", {29'd0, bus0.pcmux_sel_out}, 32'd0);
        check_output("midrst_taken", {31'd0, bus0.pred_taken_F}, 32'd0);
        check_output("midrst_perf_mis", bus0.perf_mispredicts, 32'd0);
        rst_n = 1'b1;
        tick();

        // One taken update after reset must be enough: counter restarts at 01
        apply_stimulus(32'h100, 1'b1, 32'h240, 1'b0, 32'h104);
        tick();
        set_idle();
        #1;
        check_output("post_rst_sel", {29'd0, bus0.pcmux_sel_out}, 32'd6);
        check_output("post_rst_target", bus0.pred_target_F, 32'h240);
        check_output("post_rst_perf_br", bus0.perf_branches, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dyn_branch_predictor.md
Name: dyn_branch_predictor

Overview:
- Parametrised successor to the static not-taken PC-mux selector in the BRANCH_PIPELINE component.
- Adds a PC-indexed table of 2-bit saturating counters and a tagged branch target buffer (BTB), predicting taken/not-taken and target for B-type branches at F.
- Resolves and corrects mispredictions at E, where it also updates the tables.
- Keeps the existing pcmux_sel encoding and the stall pass-through; adds mispredict recovery selects and saturating performance counters.

Parameters:
- IDX_W, 6, table index width; the table has 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 8, BTB tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).
- ENABLE_DYNAMIC, 1, 0 = static not-taken mode: F prediction is always not-taken and the tables never update.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_in  in  1  pipeline stall
- pc_F  in  32  PC of instruction in F
- instF  in  32  instruction in F
- killF  in  1  F slot killed
- pc_E  in  32  PC of instruction in E
- instE  in  32  instruction in E
- killE  in  1  E slot killed
- instD  in  32  instruction in D
- killD  in  1  D slot killed
- taken_E  in  1  resolved branch outcome in E
- target_E  in  32  resolved branch target in E
- pred_taken_E  in  1  prediction made for the E instruction, carried down the pipe
- pred_target_E  in  32  predicted target for the E instruction, carried down the pipe
- pcmux_sel_out  out  3  PC mux select
- pred_taken_F  out  1  prediction for F, to be piped with the instruction
- pred_target_F  out  32  predicted target for F, to be piped with the instruction
- predict_fail  out  1  flush of F/D on misprediction
- stall_out  out  1  stall pass-through
- perf_branches  out  PERF_W  resolved B-type count
- perf_mispredicts  out  PERF_W  mispredict count

Behaviour:
- Opcode classes on inst[6:2]: B=11000, JAL=11011, JALR=11001.
- pcmux_sel_out encoding:
  - 0 = PC+4
  - 3 = JAL target
  - 4 = JALR (D)
  - 5 = target_E
  - 6 = pred_target_F
  - 7 = pc_E+4 (recovery)
  - 1 = pass-through branch select from F for non-control instructions is dropped; non-control F gives 0.
- Reset (rst_n=0, asynchronous): all counters = CNT_INIT, all BTB valid = 0, tags/targets = 0, perf counters = 0. Outputs are combinational, so after reset pcmux_sel_out follows inputs with empty tables, i.e. never 6.
- F prediction (combinational, no latency):
  - hit = ENABLE_DYNAMIC & valid[idx] & tag match & counter[idx][1].
  - pred_taken_F = hit & B-type & !killF.
  - pred_target_F = BTB target when pred_taken_F, else pc_F+4.
- E mispredict (E valid = !killE & B-type in E):
  - fail = (taken_E != pred_taken_E) | (taken_E & pred_taken_E & target_E != pred_target_E).
- Select priority, highest first:
  1. stall_in=1: stall_out=1, pcmux_sel_out=0, predict_fail=0, no state update.
  2. E valid & fail: predict_fail=1; sel = 5 if taken_E, else 7.
  3. !killD & JALR in D: sel=4.
  4. !killF: B-type with pred_taken_F gives 6; B-type otherwise 0; JAL gives 3; JALR 0; other 0.
  5. killF: sel=0.
- predict_fail is 0 in every case except priority 2.
- Update (rising edge, when stall_in=0 and E valid):
  - Performance: perf_branches+1; if fail, perf_mispredicts+1. Both saturate at all-ones, no wrap.
  - Counters, only if ENABLE_DYNAMIC=1: counter[idxE] increments when taken_E and decrements otherwise, saturating at 3 and 0.
  - BTB, only if ENABLE_DYNAMIC=1 and taken_E: write valid=1, tagE, target_E to entry idxE.
  - A not-taken branch leaves the BTB untouched.
- Same-cycle F read and E write to the same index: F sees the old value (no bypass); the new value is visible from the next cycle.
- Aliasing: differing tags overwrite the BTB entry; counters are shared without a tag.
- Reset asserted mid-operation clears state immediately, regardless of clk or stall_in.

Test Plan:
- Reset, then B-type at pc_F=0x100 -> pred_taken_F=0, pcmux_sel_out=0, pred_target_F=0x104.
- Two resolved taken E branches at pc_E=0x100, target 0x200 (pred_taken_E=0 first, then 0) -> predict_fail=1 with sel=5 both times; counter 01→10→11; next F at 0x100 -> sel=6, pred_target_F=0x200.
- E branch pred_taken_E=1, taken_E=0, pc_E=0x100 -> predict_fail=1, sel=7; counter 11→10; perf_mispredicts increments by 1.
- stall_in=1 during an E mispredict -> stall_out=1, sel=0, predict_fail=0; counter and perf counters unchanged after the edge.
- JALR in D plus B-type in F, no E fail -> sel=4; JAL in F only -> sel=3; with ENABLE_DYNAMIC=0 and repeated taken branches -> never sel=6.
- Preload perf_mispredicts to all-ones (PERF_W=4 build), then one more mispredict -> stays 4'hF; assert rst_n=0 mid-cycle -> counters immediately back to CNT_INIT, BTB invalid.
